// File: rtl/gobang_gfx_pkg.sv
// ---------------------------------------------------------------------------
// gobang_gfx_pkg
// Shared definitions for the Gobang board graphics path:
//   - glyph index constants (stone, cursor)
//   - draw-mode bit positions (mirror, invert)
//   - pixel streamer FSM state encoding
//   - default_row(): the built-in 16x16 glyph table used when no ROM image
//     file is supplied
// ---------------------------------------------------------------------------
package gobang_gfx_pkg;

  localparam int GLYPH_STONE  = 0;
  localparam int GLYPH_CURSOR = 1;

  localparam int MODE_MIRROR  = 0;
  localparam int MODE_INVERT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Built-in 16x16 bitmaps. Both glyphs are vertically symmetric, so each
  // case label covers a row and its mirror (row and 15-row).
  function automatic logic [15:0] default_row(input int glyph, input int row);
    logic [15:0] w;
    w = 16'h0000;
    if (glyph == GLYPH_STONE) begin
      case (row)
        0, 15:   w = 16'h0102;
        1, 14:   w = 16'h0304;
        2, 13:   w = 16'h0708;
        3, 12:   w = 16'h0F10;
        default: w = 16'hDF1E;
      endcase
    end else if (glyph == GLYPH_CURSOR) begin
      case (row)
        0, 15:         w = 16'h0100;
        1, 14:         w = 16'h0300;
        2, 13:         w = 16'h0742;
        3, 12:         w = 16'h0F42;
        4, 11:         w = 16'hDF66;
        5, 6, 9, 10:   w = 16'hDF24;
        default:       w = 16'hDF18;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// ---------------------------------------------------------------------------
// glyph_rom
// Glyph bitmap ROM with a registered address and combinational data: the
// word for an address presented in cycle N is on data in cycle N+1.
//   clk   in   clock, rising edge
//   addr  in   row address (glyph * rows-per-glyph + row)
//   data  out  bitmap row, MSB = leftmost pixel
// The image is the built-in 16x16 table; other widths read as blank rows.
// ---------------------------------------------------------------------------
module glyph_rom
  import gobang_gfx_pkg::*;
#(
  parameter int    WIDTH     = 16,
  parameter int    DEPTH     = 64,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [WIDTH-1:0]         data
);

  // Builds the ROM image at elaboration/load time. The image is held as one
  // flat vector so it can be initialised from a function return value.
  function automatic logic [DEPTH*WIDTH-1:0] load_image();
    logic [WIDTH-1:0]       img [DEPTH];
    logic [DEPTH*WIDTH-1:0] flat;
    for (int i = 0; i < DEPTH; i++) begin
      if (WIDTH == 16) img[i] = WIDTH'(default_row(i / 16, i % 16));
      else             img[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) flat[i*WIDTH +: WIDTH] = img[i];
    return flat;
  endfunction

  logic [DEPTH*WIDTH-1:0]   image = load_image();
  logic [$clog2(DEPTH)-1:0] addr_reg;

  always_ff @(posedge clk) begin
    addr_reg <= addr;
  end

  // Addresses past the populated depth read as blank rows.
  assign data = (32'(addr_reg) < DEPTH) ? image[32'(addr_reg)*WIDTH +: WIDTH] : '0;

endmodule

// File: rtl/glyph_pixel_streamer.sv
// ---------------------------------------------------------------------------
// glyph_pixel_streamer
// Fetches a glyph from glyph_rom row by row and serialises it one pixel per
// cycle over a valid/ready handshake, with optional mirror and invert.
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               draw request, taken only when idle
//   glyph_sel, mode     glyph index and mode (bit0 mirror, bit1 invert),
//                       captured with start
//   abort               cancel the current draw
//   busy                draw in progress (FETCH or STREAM)
//   pix_valid/pix_ready pixel handshake
//   pix_data            pixel value, 1 = foreground
//   pix_last_col        last pixel of a row
//   pix_last            last pixel of the glyph
// ---------------------------------------------------------------------------
module glyph_pixel_streamer
  import gobang_gfx_pkg::*;
#(
  parameter int    GLYPH_W    = 16,
  parameter int    GLYPH_H    = 16,
  parameter int    NUM_GLYPHS = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(NUM_GLYPHS)-1:0] glyph_sel,
  input  logic [1:0]                    mode,
  input  logic                          abort,
  output logic                          busy,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_data,
  output logic                          pix_last_col,
  output logic                          pix_last
);

  localparam int DEPTH = NUM_GLYPHS * GLYPH_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int RW    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  state_e             state_reg, state_next;
  logic [CW-1:0]      col_reg, col_next;
  logic [RW-1:0]      row_reg, row_next;
  logic [AW-1:0]      addr_reg, addr_next;
  logic [GLYPH_W-1:0] shift_reg, shift_next;
  logic [1:0]         mode_reg, mode_next;
  logic               blank_reg, blank_next;

  logic [GLYPH_W-1:0] rom_data;
  logic [GLYPH_W-1:0] rom_rev;
  logic [GLYPH_W-1:0] load_word;
  logic               streaming;
  logic               col_end;
  logic               row_end;

  // The ROM registers addr_next itself, so its output always reflects
  // addr_reg: in FETCH that is row 0, and in STREAM it is already the next
  // row, which is what lets rows follow each other without a bubble.
  glyph_rom #(
    .WIDTH     (GLYPH_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (addr_next),
    .data (rom_data)
  );

  for (genvar gi = 0; gi < GLYPH_W; gi++) begin : g_rev
    assign rom_rev[gi] = rom_data[GLYPH_W-1-gi];
  end

  // Mirroring is done at load time so the shifter always emits its MSB.
  // An out-of-range glyph index loads blank rows instead of aliasing.
  assign load_word = blank_reg ? '0 :
                     (mode_reg[MODE_MIRROR] ? rom_rev : rom_data);

  assign streaming = (state_reg == ST_STREAM);
  assign col_end   = (col_reg == CW'(GLYPH_W - 1));
  assign row_end   = (row_reg == RW'(GLYPH_H - 1));

  assign busy         = (state_reg != ST_IDLE);
  assign pix_valid    = streaming;
  assign pix_data     = streaming & (shift_reg[GLYPH_W-1] ^ mode_reg[MODE_INVERT]);
  assign pix_last_col = streaming & col_end;
  assign pix_last     = streaming & col_end & row_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      addr_reg  <= '0;
      shift_reg <= '0;
      mode_reg  <= '0;
      blank_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      addr_reg  <= addr_next;
      shift_reg <= shift_next;
      mode_reg  <= mode_next;
      blank_reg <= blank_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    addr_next  = addr_reg;
    shift_next = shift_reg;
    mode_next  = mode_reg;
    blank_next = blank_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mode_next  = mode;
          blank_next = (32'(glyph_sel) >= NUM_GLYPHS);
          addr_next  = AW'(glyph_sel) * AW'(GLYPH_H);
          col_next   = '0;
          row_next   = '0;
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        shift_next = load_word;
        addr_next  = addr_reg + AW'(1);
        state_next = ST_STREAM;
      end

      ST_STREAM: begin
        if (pix_ready) begin
          if (col_end) begin
            // Row boundary: reload from the prefetched row and prefetch the
            // one after it. On the final pixel this harmlessly reads past
            // the glyph; the FSM leaves STREAM at the same edge.
            col_next   = '0;
            row_next   = row_reg + RW'(1);
            shift_next = load_word;
            addr_next  = addr_reg + AW'(1);
            if (row_end) state_next = ST_IDLE;
          end else begin
            col_next   = col_reg + CW'(1);
            shift_next = shift_reg << 1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // abort overrides any transition; in IDLE it simply keeps the FSM idle.
    if (abort) state_next = ST_IDLE;
  end

endmodule

// File: tb/tb_glyph_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tb_glyph_pixel_streamer
// Bench for glyph_pixel_streamer (default 16x16, 4 glyphs, built-in table).
// A behavioural model tracks the expected busy/valid/pixel index and the
// expected pixel image; a compare process checks the DUT on every cycle.
// Directed draws add literal checks on selected rows and timings.
// ---------------------------------------------------------------------------
module tb_glyph_pixel_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pix_ready = 1'b0;
  logic [1:0] glyph_sel = 2'd0;
  logic [1:0] mode = 2'd0;
  logic       busy, pix_valid, pix_data, pix_last_col, pix_last;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] tbl [4][16];
  logic        exp_pix [256];
  logic        ref0 [256];
  logic        got_q [$];
  int          first_valid_cyc;
  int          last_idx;
  int          t0;

  // model state
  bit   m_busy  = 1'b0;
  int   m_delay = 0;
  int   m_idx   = 0;
  logic m_valid;
  assign m_valid = m_busy && (m_delay == 0);

  glyph_pixel_streamer #(
    .GLYPH_W    (16),
    .GLYPH_H    (16),
    .NUM_GLYPHS (4),
    .INIT_FILE  ("")
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .glyph_sel    (glyph_sel),
    .mode         (mode),
    .abort        (abort),
    .busy         (busy),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_last_col (pix_last_col),
    .pix_last     (pix_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tbl[0] = '{16'h0102, 16'h0304, 16'h0708, 16'h0F10,
               16'hDF1E, 16'hDF1E, 16'hDF1E, 16'hDF1E,
               16'hDF1E, 16'hDF1E, 16'hDF1E, 16'hDF1E,
               16'h0F10, 16'h0708, 16'h0304, 16'h0102};
    tbl[1] = '{16'h0100, 16'h0300, 16'h0742, 16'h0F42,
               16'hDF66, 16'hDF24, 16'hDF24, 16'hDF18,
               16'hDF18, 16'hDF24, 16'hDF24, 16'hDF66,
               16'h0F42, 16'h0742, 16'h0300, 16'h0100};
    for (int r = 0; r < 16; r++) begin
      tbl[2][r] = 16'h0000;
      tbl[3][r] = 16'h0000;
    end
  end

  // Pixel p of a glyph: row p/16, column p%16; the leftmost column is the
  // word MSB unless mirrored, then inverted if requested.
  function automatic logic spec_pixel(input int g, input int m, input int p);
    logic [15:0] w;
    int          c;
    w = tbl[g][p / 16];
    c = p % 16;
    return (m[0] ? w[c] : w[15 - c]) ^ m[1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: a draw is busy for one fetch cycle, then presents
  // pixels 0..255, advancing on each accepted pixel.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy  = 1'b0;
        m_delay = 0;
        m_idx   = 0;
      end else if (m_busy && abort) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          for (int p = 0; p < 256; p++)
            exp_pix[p] = spec_pixel(int'(glyph_sel), int'(mode), p);
          m_busy  = 1'b1;
          m_delay = 1;
          m_idx   = 0;
        end
      end else if (m_delay > 0) begin
        m_delay = 0;
      end else if (pix_ready) begin
        if (m_idx == 255) m_busy = 1'b0;
        else              m_idx++;
      end
    end
  end

  // Compare and record on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("pix_valid", 32'(pix_valid), 32'(m_valid));
        if (m_valid) begin
          check("pix_data", 32'(pix_data), 32'(exp_pix[m_idx]));
          check("pix_last_col", 32'(pix_last_col), 32'((m_idx % 16) == 15));
          check("pix_last", 32'(pix_last), 32'(m_idx == 255));
        end
        if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pix_valid && pix_ready) begin
          if (pix_last) last_idx = got_q.size();
          got_q.push_back(pix_data);
        end
      end
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic run_draw(input int g, input int m, input bit rnd,
                          input int abort_at, input bit poke);
    int budget;
    got_q.delete();
    first_valid_cyc = -1;
    last_idx        = -1;
    glyph_sel = g[1:0];
    mode      = m[1:0];
    start     = 1'b1;
    abort     = 1'b0;
    pix_ready = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start  = 1'b0;
    budget = 0;
    while (m_busy && budget < 3000) begin
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        start     = 1'($urandom_range(0, 1));
        glyph_sel = 2'($urandom_range(0, 3));
        mode      = 2'($urandom_range(0, 3));
      end
      abort = (abort_at >= 0 && m_valid && m_idx == abort_at);
      @(posedge clk); #1;
      budget++;
    end
    abort     = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b1;
    if (budget >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL draw_timeout glyph %0d: got %0d cycles, expected fewer than 3000", g, budget);
    end
  endtask

  function automatic logic [15:0] got_row(input int r);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[15 - i] = got_q[r * 16 + i];
    return v;
  endfunction

  function automatic int count_ones();
    int n = 0;
    foreach (got_q[i]) if (got_q[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    int mism;
    int budget;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pix_valid", 32'(pix_valid), 32'd0);
    check("reset_pix_data", 32'(pix_data), 32'd0);
    check("reset_pix_last_col", 32'(pix_last_col), 32'd0);
    check("reset_pix_last", 32'(pix_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic draw: stone, no mode, ready high
    run_draw(0, 0, 1'b0, -1, 1'b0);
    check("basic_first_valid_cycle", 32'(first_valid_cyc), 32'(t0 + 2));
    check("basic_count", 32'(got_q.size()), 32'd256);
    check("basic_row0", 32'(got_row(0)), 32'b0000000100000010);
    check("basic_last_index", 32'(last_idx), 32'd255);
    check("basic_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 256; i++) ref0[i] = got_q[i];

    // Mirror + invert cursor, started in the idle cycle right after the last pixel
    run_draw(1, 3, 1'b0, -1, 1'b0);
    check("mi_first_valid_cycle", 32'(first_valid_cyc), 32'(t0 + 2));
    check("mi_row2", 32'(got_row(2)), 32'b1011110100011111);
    check("mi_count", 32'(got_q.size()), 32'd256);

    // Backpressure: same stream as the stall-free stone draw
    run_draw(0, 0, 1'b1, -1, 1'b0);
    check("bp_count", 32'(got_q.size()), 32'd256);
    mism = 0;
    for (int i = 0; i < 256; i++) if (got_q[i] !== ref0[i]) mism++;
    check("bp_stream_mismatches", 32'(mism), 32'd0);

    // Abort at pixel 40, then a full draw from row 0
    run_draw(0, 0, 1'b0, 40, 1'b0);
    check("abort_pix_valid", 32'(pix_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    run_draw(0, 0, 1'b0, -1, 1'b0);
    check("post_abort_count", 32'(got_q.size()), 32'd256);
    mism = 0;
    for (int i = 0; i < 256; i++) if (got_q[i] !== ref0[i]) mism++;
    check("post_abort_mismatches", 32'(mism), 32'd0);

    // start/glyph_sel/mode poked while busy, with random backpressure
    run_draw(1, 0, 1'b1, -1, 1'b1);
    check("poke_count", 32'(got_q.size()), 32'd256);
    check("poke_row4", 32'(got_row(4)), 32'hDF66);

    // Empty glyph: zeros, or ones when inverted
    run_draw(2, 0, 1'b0, -1, 1'b0);
    check("blank_count", 32'(got_q.size()), 32'd256);
    check("blank_ones", 32'(count_ones()), 32'd0);
    run_draw(2, 2, 1'b1, -1, 1'b0);
    check("blank_inv_ones", 32'(count_ones()), 32'd256);

    // Asynchronous reset in the middle of a draw
    glyph_sel = 2'd1;
    mode      = 2'd0;
    pix_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    budget = 0;
    while (!(m_valid && m_idx == 100) && budget < 1000) begin
      @(posedge clk); #1;
      budget++;
    end
    check("reach_pixel_100", 32'(budget < 1000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_pix_valid", 32'(pix_valid), 32'd0);
    check("areset_pix_data", 32'(pix_data), 32'd0);
    check("areset_pix_last_col", 32'(pix_last_col), 32'd0);
    check("areset_pix_last", 32'(pix_last), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery: mirrored stone
    run_draw(0, 1, 1'b0, -1, 1'b0);
    check("mirror_row0", 32'(got_row(0)), 32'b0100000010000000);
    check("mirror_count", 32'(got_q.size()), 32'd256);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_pixel_streamer.md
# glyph_pixel_streamer

Parametrised glyph ROM with an on-chip pixel serializer for the Gobang board renderer. On a draw request it fetches the selected glyph (stone or cursor marker) row by row from an internal ROM and streams one pixel per cycle over a valid/ready handshake. Optional horizontal mirroring and inversion are applied on the fly. It sits between the board/cursor controller and the VGA compositor and replaces fixed, single-bitmap lookups.

## Interface
- GLYPH_W, 16, pixels per glyph row (ROM word width)
- GLYPH_H, 16, rows per glyph
- NUM_GLYPHS, 4, glyphs held in the ROM
- INIT_FILE, "", binary $readmemb image; empty selects the built-in default table (valid only for 16x16)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  draw request, sampled only in IDLE
- glyph_sel  in  $clog2(NUM_GLYPHS)  glyph index, captured with start
- mode  in  2  bit0 mirror (LSB first), bit1 invert; captured with start
- abort  in  1  cancel the current draw
- busy  out  1  high from the cycle after start is accepted until the draw ends
- pix_valid  out  1  pix_data is valid
- pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready
- pix_data  out  1  pixel value (1 = foreground)
- pix_last_col  out  1  current pixel is the last of its row
- pix_last  out  1  current pixel is the last of the glyph

## Operation
- FSM states: IDLE, FETCH, STREAM.
- **IDLE:** start=1 captures glyph_sel and mode, drives ROM address glyph_sel*GLYPH_H, resets the row and column counters, and goes to FETCH.
- **FETCH:** loads the ROM word into the shift register (bit-reversed if mirror is set), advances the ROM address to the next row, and goes to STREAM.
- **STREAM:**
  - pix_data = shift MSB XOR mode[1].
  - Each handshake shifts left by one and increments the column.
  - On a handshake at column GLYPH_W-1, the column wraps to 0, the row increments, and the shift register reloads from the ROM output (next row, already addressed).
  - After loading, the ROM address advances again. No bubbles between rows.
- pix_valid holds with pix_data stable while pix_ready=0 (no drop, no advance).
- On a handshake with pix_last=1 the FSM returns to IDLE; pix_valid=0 on the next cycle.
- abort has priority over everything in any state: next cycle IDLE, pix_valid=0, busy=0. An abort in IDLE is ignored.
- start while busy is ignored; no queueing.
- A glyph_sel ≥ NUM_GLYPHS yields all-zero rows (all ones if inverted), still GLYPH_W*GLYPH_H pixels.
- ROM address width is $clog2(NUM_GLYPHS*GLYPH_H). Counters wrap naturally; no arithmetic overflow is possible.
- **Default table:** glyph 0 is the round stone, glyph 1 is the cross cursor, glyphs 2–3 are zero.
  - Glyph 0 rows 0..15: 0102, 0304, 0708, 0F10, DF1E ×8, 0F10, 0708, 0304, 0102.
  - Glyph 1 rows 0..15: 0100, 0300, 0742, 0F42, DF66, DF24, DF24, DF18, DF18, DF24, DF24, DF66, 0F42, 0742, 0300, 0100.

## Timing
- **Reset values:** state=IDLE; busy, pix_valid, pix_data, pix_last_col and pix_last = 0; counters and address = 0.
- The ROM has a registered address and combinational data, so data is available one cycle after the address.
- **Latency:** start at cycle 0 gives busy=1 and FETCH at cycle 1, and first pix_valid at cycle 2.
- **Throughput:** 1 pixel/cycle with pix_ready held high. The draw spans cycles 2 .. 2+GLYPH_W*GLYPH_H-1 (cycles 2..257 for 16x16).
- A start can be accepted in the cycle after pix_last is consumed (IDLE).
- rst_n deassertion is assumed synchronised externally. Reset mid-draw clears all state immediately.

## Structure
- Shared package gobang_gfx_pkg holds:
  - the glyph index constants (GLYPH_STONE=0, GLYPH_CURSOR=1);
  - the mode bit positions (MODE_MIRROR=0, MODE_INVERT=1);
  - the FSM state encoding.
- Sub-module glyph_rom (params WIDTH, DEPTH, INIT_FILE; clk, addr, data; registered address) holds the table.
- glyph_pixel_streamer holds the FSM, counters and shift register.

## Test plan
- **Basic draw:** reset, start with glyph_sel=0, mode=0, pix_ready=1 → pix_valid is first high at cycle 2. The first 16 pixels equal 0x0102 MSB-first: 0000000100000010. pix_last_col is high on pixels 15, 31, … pix_last is high only on pixel 255, and busy falls the cycle after.
- **Mirror + invert:** glyph_sel=1, mode=3 → row 2 (0x0742) is emitted as ~bitrev = 1011110100011111. Rows arrive contiguously with no bubble.
- **Backpressure:** pix_ready toggles randomly → pix_data is stable while stalled. The total handshakes equal 256 and the sequence matches the stall-free stream.
- **Abort:** abort at pixel 40 → the next cycle shows pix_valid=0 and busy=0. A following start draws a full glyph from row 0.
- **Ignored requests:** start pulsed while busy → no effect on the stream. glyph_sel=2 → 256 zeros.
- **Async reset mid-draw:** rst_n low at pixel 100 → all outputs are 0 immediately, without waiting for a clock edge.
